// File: rtl/decode_branch_unit.sv
// ---------------------------------------------------------------------------
// decode_branch_unit
//
// Decode stage sitting on the consuming end of the fetch interface. Decodes
// the fetched instruction, drives register-file read addresses, registers the
// decoded fields into the ID/EX latch and produces all fetch control:
// load-use stall, BEQ/JMP redirect with a one-slot wrong-path squash, and a
// sticky HALT.
//
// Ports:
//   clk, reset              clock; asynchronous active-high reset
//   if_instruction/pc/valid fetched instruction, its PC, valid flag
//   rs1_addr, rs2_addr      register-file read addresses (combinational)
//   rs1_data, rs2_data      register-file read data (same cycle)
//   stall, flush, jump      fetch control (combinational)
//   pc_sel, branch_target   taken-BEQ select and redirect target
//   id_*                    registered ID/EX latch contents
//   halted                  HALT retired; sticky until reset
// ---------------------------------------------------------------------------
module decode_branch_unit #(
    parameter logic [3:0] OP_LOAD  = 4'h8,
    parameter logic [3:0] OP_STORE = 4'h9,
    parameter logic [3:0] OP_BEQ   = 4'hB,
    parameter logic [3:0] OP_JMP   = 4'hC,
    parameter logic [3:0] OP_HALT  = 4'hF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] if_instruction,
    input  logic [7:0]  if_pc,
    input  logic        if_valid,
    output logic [3:0]  rs1_addr,
    output logic [3:0]  rs2_addr,
    input  logic [7:0]  rs1_data,
    input  logic [7:0]  rs2_data,
    output logic        stall,
    output logic        flush,
    output logic        jump,
    output logic        pc_sel,
    output logic [7:0]  branch_target,
    output logic        id_valid,
    output logic [3:0]  id_opcode,
    output logic [3:0]  id_rd,
    output logic [7:0]  id_rs1_val,
    output logic [7:0]  id_rs2_val,
    output logic [7:0]  id_imm,
    output logic [7:0]  id_pc,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SQUASH = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        id_valid_q, id_valid_d;
    logic [3:0]  id_opcode_q, id_opcode_d;
    logic [3:0]  id_rd_q, id_rd_d;
    logic [7:0]  id_rs1_val_q, id_rs1_val_d;
    logic [7:0]  id_rs2_val_q, id_rs2_val_d;
    logic [7:0]  id_imm_q, id_imm_d;
    logic [7:0]  id_pc_q, id_pc_d;
    logic        halted_q, halted_d;

    logic [3:0]  op, rd_f, rs1_f, rs2_f, rs2_sel;
    logic        reads_rs1, reads_rs2;
    logic        fire, hazard, issue, beq_taken, jmp_go;
    logic [7:0]  imm;
    logic [7:0]  target;

    assign op    = if_instruction[15:12];
    assign rd_f  = if_instruction[11:8];
    assign rs1_f = if_instruction[7:4];
    assign rs2_f = if_instruction[3:0];

    // STORE reads its data register from the rd field.
    assign rs2_sel = (op == OP_STORE) ? rd_f : rs2_f;

    always_comb begin
        reads_rs1 = 1'b0;
        reads_rs2 = 1'b0;
        imm       = 8'd0;
        if (op >= 4'd1 && op <= 4'd4) begin
            reads_rs1 = 1'b1;
            reads_rs2 = 1'b1;
        end else if (op == 4'd5 || op == OP_LOAD) begin
            reads_rs1 = 1'b1;
            imm       = {4'd0, rs2_f};
        end else if (op == OP_STORE || op == OP_BEQ) begin
            reads_rs1 = 1'b1;
            reads_rs2 = 1'b1;
        end
    end

    always_comb begin
        fire   = if_valid && (state_q == ST_RUN);
        // Hazard only against sources this instruction really reads, so a
        // stale field in an unused slot never causes a spurious stall.
        hazard = fire && id_valid_q && (id_opcode_q == OP_LOAD) &&
                 ((reads_rs1 && (id_rd_q == rs1_f)) ||
                  (reads_rs2 && (id_rd_q == rs2_sel)));
        issue     = fire && !hazard;
        beq_taken = issue && (op == OP_BEQ) && (rs1_data == rs2_data);
        jmp_go    = issue && (op == OP_JMP);

        target = 8'd0;
        if (beq_taken) begin
            target = if_pc + 8'd1 + {{4{rd_f[3]}}, rd_f};
        end else if (jmp_go) begin
            target = if_instruction[11:4];
        end
    end

    always_comb begin
        state_d      = state_q;
        id_valid_d   = issue;
        id_opcode_d  = id_opcode_q;
        id_rd_d      = id_rd_q;
        id_rs1_val_d = id_rs1_val_q;
        id_rs2_val_d = id_rs2_val_q;
        id_imm_d     = id_imm_q;
        id_pc_d      = id_pc_q;

        if (issue) begin
            id_opcode_d  = op;
            id_rd_d      = rd_f;
            id_rs1_val_d = rs1_data;
            id_rs2_val_d = rs2_data;
            id_imm_d     = imm;
            id_pc_d      = if_pc;
        end

        case (state_q)
            ST_RUN: begin
                if (beq_taken || jmp_go) begin
                    state_d = ST_SQUASH;
                end else if (issue && (op == OP_HALT)) begin
                    state_d = ST_HALTED;
                end
            end
            ST_SQUASH: state_d = ST_RUN;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase

        halted_d = (state_d == ST_HALTED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RUN;
            id_valid_q   <= 1'b0;
            id_opcode_q  <= 4'd0;
            id_rd_q      <= 4'd0;
            id_rs1_val_q <= 8'd0;
            id_rs2_val_q <= 8'd0;
            id_imm_q     <= 8'd0;
            id_pc_q      <= 8'd0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            id_valid_q   <= id_valid_d;
            id_opcode_q  <= id_opcode_d;
            id_rd_q      <= id_rd_d;
            id_rs1_val_q <= id_rs1_val_d;
            id_rs2_val_q <= id_rs2_val_d;
            id_imm_q     <= id_imm_d;
            id_pc_q      <= id_pc_d;
            halted_q     <= halted_d;
        end
    end

    assign rs1_addr      = rs1_f;
    assign rs2_addr      = rs2_sel;
    assign stall         = hazard;
    assign flush         = beq_taken || jmp_go;
    assign jump          = jmp_go;
    assign pc_sel        = beq_taken;
    assign branch_target = target;
    assign id_valid      = id_valid_q;
    assign id_opcode     = id_opcode_q;
    assign id_rd         = id_rd_q;
    assign id_rs1_val    = id_rs1_val_q;
    assign id_rs2_val    = id_rs2_val_q;
    assign id_imm        = id_imm_q;
    assign id_pc         = id_pc_q;
    assign halted        = halted_q;

endmodule

// File: tb/tb_decode_branch_unit.sv
// ---------------------------------------------------------------------------
// tb_decode_branch_unit
//
// Bench for decode_branch_unit. A stimulus process drives one instruction per
// cycle, evaluates an instruction-level reference model and pushes each
// expected ID/EX entry into a scoreboard queue; a monitor pops and compares
// whenever the DUT presents an ID/EX entry.
// ---------------------------------------------------------------------------
module tb_decode_branch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] if_instruction = 16'd0;
    logic [7:0]  if_pc = 8'd0;
    logic        if_valid = 1'b0;
    logic [3:0]  rs1_addr, rs2_addr;
    logic [7:0]  rs1_data = 8'd0, rs2_data = 8'd0;
    logic        stall, flush, jump, pc_sel;
    logic [7:0]  branch_target;
    logic        id_valid;
    logic [3:0]  id_opcode, id_rd;
    logic [7:0]  id_rs1_val, id_rs2_val, id_imm, id_pc;
    logic        halted;

    decode_branch_unit dut (
        .clk(clk), .reset(reset),
        .if_instruction(if_instruction), .if_pc(if_pc), .if_valid(if_valid),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .stall(stall), .flush(flush), .jump(jump), .pc_sel(pc_sel),
        .branch_target(branch_target),
        .id_valid(id_valid), .id_opcode(id_opcode), .id_rd(id_rd),
        .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val),
        .id_imm(id_imm), .id_pc(id_pc), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [3:0] rd;
        logic [7:0] v1;
        logic [7:0] v2;
        logic [7:0] imm;
        logic [7:0] pc;
    } rec_t;

    typedef logic [3:0] reg_q_t[$];

    rec_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state, at instruction granularity.
    bit         m_halted   = 0;
    bit         m_squash   = 0;
    bit         m_ld_valid = 0;
    logic [3:0] m_ld_rd    = 4'd0;
    bit         m_vld_prev = 0;
    bit         last_stall = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Registers an instruction reads, straight from the opcode table.
    function automatic reg_q_t sources(input logic [15:0] ins);
        reg_q_t s;
        int op;
        op = int'(ins[15:12]);
        if (op >= 1 && op <= 4) begin s.push_back(ins[7:4]); s.push_back(ins[3:0]); end
        else if (op == 5 || op == 8) s.push_back(ins[7:4]);
        else if (op == 9) begin s.push_back(ins[7:4]); s.push_back(ins[11:8]); end
        else if (op == 11) begin s.push_back(ins[7:4]); s.push_back(ins[3:0]); end
        return s;
    endfunction

    task automatic step(input logic [15:0] ins, input logic [7:0] pc, input logic v,
                        input logic [7:0] d1, input logic [7:0] d2);
        int op, off;
        bit e_stall, e_issue, e_pcsel, e_jump;
        logic [7:0] e_tgt;
        reg_q_t src;
        rec_t r;
        @(negedge clk);
        if_instruction = ins; if_pc = pc; if_valid = v; rs1_data = d1; rs2_data = d2;
        #1;
        op = int'(ins[15:12]);
        e_stall = 0; e_issue = 0; e_pcsel = 0; e_jump = 0; e_tgt = 8'd0;
        if (!m_halted && !m_squash && v) begin
            src = sources(ins);
            foreach (src[i]) if (m_ld_valid && src[i] == m_ld_rd) e_stall = 1;
            if (!e_stall) begin
                e_issue = 1;
                r.op = ins[15:12]; r.rd = ins[11:8]; r.v1 = d1; r.v2 = d2; r.pc = pc;
                r.imm = (op == 5 || op == 8) ? {4'd0, ins[3:0]} : 8'd0;
                exp_q.push_back(r);
                if (op == 11 && d1 == d2) begin
                    off = (ins[11:8] >= 8) ? int'(ins[11:8]) - 16 : int'(ins[11:8]);
                    e_pcsel = 1;
                    e_tgt = 8'((int'(pc) + 1 + off + 256) % 256);
                end else if (op == 12) begin
                    e_jump = 1;
                    e_tgt = ins[11:4];
                end
            end
        end
        chk("rs1_addr", rs1_addr, ins[7:4]);
        chk("rs2_addr", rs2_addr, (op == 9) ? ins[11:8] : ins[3:0]);
        chk("stall", stall, e_stall);
        chk("flush", flush, e_pcsel | e_jump);
        chk("jump", jump, e_jump);
        chk("pc_sel", pc_sel, e_pcsel);
        chk("branch_target", branch_target, e_tgt);
        chk("halted", halted, m_halted);
        chk("id_valid", id_valid, m_vld_prev);
        m_squash   = e_pcsel | e_jump;
        m_halted   = m_halted | (e_issue && op == 15);
        m_ld_valid = e_issue && op == 8;
        m_ld_rd    = ins[11:8];
        m_vld_prev = e_issue;
        last_stall = e_stall;
    endtask

    task automatic do_reset();
        @(negedge clk);
        if_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_id_valid", id_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_ctrl", {stall, flush, jump, pc_sel}, 4'd0);
        chk("rst_target", branch_target, 0);
        chk("rst_fields", {id_opcode, id_rd, id_rs1_val, id_rs2_val, id_imm, id_pc}, 0);
        m_halted = 0; m_squash = 0; m_ld_valid = 0; m_vld_prev = 0; last_stall = 0;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Scoreboard monitor.
    initial begin
        rec_t r;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && (id_valid || exp_q.size() > 0)) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_issue", id_valid, 0);
                end else begin
                    r = exp_q.pop_front();
                    chk("sb_id_valid", id_valid, 1);
                    chk("sb_opcode", id_opcode, r.op);
                    chk("sb_rd", id_rd, r.rd);
                    chk("sb_rs1_val", id_rs1_val, r.v1);
                    chk("sb_rs2_val", id_rs2_val, r.v2);
                    chk("sb_imm", id_imm, r.imm);
                    chk("sb_pc", id_pc, r.pc);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation timed out at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] ins;
        logic [7:0]  pc;
        logic        v;
        logic [7:0]  d1, d2;
        int          hcnt;

        #1;
        chk("rst_async_id_valid", id_valid, 0);
        do_reset();

        // ADD r3,r1,r2 at 0x10
        step(16'h1312, 8'h10, 1, 8'd5, 8'd7);
        // LOAD r4 then dependent ADD: one stall, then issue
        step(16'h8413, 8'h11, 1, 8'd1, 8'd2);
        step(16'h1541, 8'h12, 1, 8'd3, 8'd4);
        chk("load_use_stall", stall, 1);
        step(16'h1541, 8'h12, 1, 8'd3, 8'd4);
        chk("load_use_released", stall, 0);
        // LOAD r4 then independent ADD: no stall
        step(16'h8400, 8'h13, 1, 8'd0, 8'd0);
        step(16'h1512, 8'h14, 1, 8'd6, 8'd6);
        chk("no_false_stall", stall, 0);
        // BEQ at 0x20 offset -2, equal -> 0x1F, then squash slot
        step(16'hBE12, 8'h20, 1, 8'd9, 8'd9);
        chk("beq_target_back", branch_target, 8'h1F);
        step(16'h1312, 8'h21, 1, 8'd1, 8'd1);
        // BEQ at 0xFF offset 3 -> wraps to 0x03
        step(16'hB312, 8'hFF, 1, 8'd2, 8'd2);
        chk("beq_target_wrap", branch_target, 8'h03);
        step(16'h1312, 8'h00, 1, 8'd1, 8'd1);
        // Same BEQ, unequal data: no redirect, next slot issues
        step(16'hB312, 8'hFF, 1, 8'd2, 8'd3);
        chk("beq_not_taken", pc_sel, 0);
        step(16'h2312, 8'h00, 1, 8'd1, 8'd1);
        // JMP 0x5A
        step(16'hC5A0, 8'h40, 1, 8'd0, 8'd0);
        chk("jmp_target", branch_target, 8'h5A);
        step(16'h1312, 8'h41, 1, 8'd1, 8'd1);
        // LOAD r1 then BEQ r1,r2: stall first, resolve next
        step(16'h8100, 8'h50, 1, 8'd0, 8'd0);
        step(16'hB012, 8'h51, 1, 8'd4, 8'd4);
        chk("hazard_beats_branch", pc_sel, 0);
        step(16'hB012, 8'h51, 1, 8'd4, 8'd4);
        chk("branch_after_stall", pc_sel, 1);
        step(16'h0000, 8'h52, 1, 8'd0, 8'd0);
        // HALT then 10 valid slots ignored
        step(16'hF000, 8'h60, 1, 8'd0, 8'd0);
        for (int i = 0; i < 10; i++) step(16'hB011, 8'(8'h61 + i), 1, 8'd1, 8'd1);
        chk("halted_sticky", halted, 1);
        do_reset();

        // Randomized phase
        ins = 16'd0; pc = 8'd0; hcnt = 0;
        for (int n = 0; n < 2000; n++) begin
            if (!last_stall) begin
                ins[15:12] = 4'($urandom_range(0, 15));
                if (ins[15:12] == 4'hF && $urandom_range(0, 19) != 0) ins[15:12] = 4'h1;
                ins[11:8] = 4'($urandom_range(0, 3));
                ins[7:4]  = 4'($urandom_range(0, 3));
                ins[3:0]  = 4'($urandom_range(0, 15) < 12 ? $urandom_range(0, 3) : $urandom_range(0, 15));
                if ($urandom_range(0, 9) == 0) ins[11:8] = 4'($urandom_range(0, 15));
                pc = 8'($urandom_range(0, 255));
                v  = ($urandom_range(0, 99) < 85);
            end
            d1 = 8'($urandom_range(0, 3));
            d2 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
            step(ins, pc, v, d1, d2);
            if (m_halted) hcnt++;
            if (hcnt > 4) begin
                hcnt = 0;
                do_reset();
            end
        end

        @(negedge clk);
        if_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
